ram_access_ctrl: RTL and testbench

- Initiator side of the 4-lane byte RAM: sequences byte, half and word loads and stores from the multicycle core onto the RAM's wr_en, index0-3, entry0-3 and entry_out0-3 lanes.
- The RAM is level-sensitive, with no clock and with writes triggered by index or wr_en changes. This block therefore guarantees indices and entries are stable before wr_en rises and held until after it falls.
- Sits between the multicycle control FSM and the data RAM instance. Little-endian: lane k carries byte k at address addr+k.

---
 rtl/ram_access_ctrl_pkg.sv | 9 +
 rtl/ram_access_ctrl_if.sv | 20 ++
 rtl/ram_access_ctrl_load_extend.sv | 14 +
 rtl/ram_access_ctrl.sv | 81 ++++++++
 tb/tb_ram_access_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// ram_ctrl_pkg: shared size/state encodings and lane count for the RAM access controller
package ram_ctrl_pkg;
  localparam int LANES = 4;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, CAPTURE, RESP} state_e;
  function automatic logic [2:0] nbytes(size_e s);
    return s == SZ_BYTE ? 3'd1 : s == SZ_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if: core request/response handshake plus the 4-lane level-sensitive RAM bus
interface ram_access_ctrl_if;
  import ram_ctrl_pkg::*;
  logic req_valid, req_ready, req_we, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic ram_wr_en;
  logic [LANES-1:0][31:0] ram_index;
  logic [LANES-1:0][7:0] ram_entry, ram_entry_out;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_entry_out,
    input  req_ready, resp_valid, resp_err, resp_rdata, ram_wr_en, ram_index, ram_entry
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_entry_out,
    output req_ready, resp_valid, resp_err, resp_rdata, ram_wr_en, ram_index, ram_entry
  );
endinterface

// File: rtl/ram_access_ctrl_load_extend.sv
// ram_load_extend: combinational 4-lane to 32-bit load extender (byte/half sign or zero, word as-is)
module ram_load_extend
  import ram_ctrl_pkg::*;
(
  input  size_e                 size_i,
  input  logic                  unsigned_i,
  input  logic [LANES-1:0][7:0] lane_i,
  output logic [31:0]           data_o
);
  always_comb
    data_o = size_i == SZ_BYTE ? {{24{~unsigned_i & lane_i[0][7]}}, lane_i[0]}
           : size_i == SZ_HALF ? {{16{~unsigned_i & lane_i[1][7]}}, lane_i[1], lane_i[0]}
           : lane_i;
endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sequences loads/stores onto a clockless 4-lane byte RAM with stable index/entry around wr_en.
// Optional MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int MEM_SIZE    = 1024,
  parameter int ENTRY_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  ram_access_ctrl_if.slave bus
);
  if (ENTRY_WIDTH != 8) begin : g_bad_width
    $error("ram_access_ctrl: ENTRY_WIDTH must be 8");
  end
  state_e state_q, state_d;
  size_e size_q, req_sz;
  logic we_q, uns_q, err_q, wr_en_q, accept, bad;
  logic [32:0] last;
  logic [LANES-1:0][31:0] index_q, index_d;
  logic [LANES-1:0][7:0] entry_q, entry_d;
  logic [31:0] rdata_q, rdata_d, ext;
  ram_load_extend u_ext (.size_i(size_q), .unsigned_i(uns_q), .lane_i(bus.ram_entry_out), .data_o(ext));
  always_comb begin
    req_sz = size_e'(bus.req_size);
    accept = state_q == IDLE && bus.req_valid;
    last = {1'b0, bus.req_addr} + 33'(nbytes(req_sz)) - 33'd1;
    bad = req_sz == SZ_ILL || last >= 33'(MEM_SIZE);
`ifdef MISALIGN_TRAP_EN
    bad = bad || (req_sz == SZ_HALF && bus.req_addr[0]) || (req_sz == SZ_WORD && bus.req_addr[1:0] != 2'b00);
`endif
    // half duplicates byte1 onto lanes 1-3 so redundant lanes write identical data
    for (int k = 0; k < LANES; k++) begin
      index_d[k] = req_sz == SZ_WORD ? bus.req_addr + 32'(k)
                 : req_sz == SZ_HALF && k > 0 ? bus.req_addr + 32'd1 : bus.req_addr;
      entry_d[k] = req_sz == SZ_WORD ? bus.req_wdata[8*k +: 8]
                 : req_sz == SZ_HALF && k > 0 ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
    end
    state_d = state_q == IDLE ? (accept ? (bad ? RESP : SETUP) : IDLE)
            : state_q == SETUP ? (we_q ? STROBE : CAPTURE)
            : state_q == STROBE ? RELEASE
            : state_q == RELEASE || state_q == CAPTURE ? RESP
            : IDLE;
    rdata_d = state_q == CAPTURE ? ext : accept ? '0 : rdata_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wr_en_q <= 1'b0;
      rdata_q <= '0;
      index_q <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= state_d == STROBE;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q   <= bus.req_we;
        size_q <= req_sz;
        uns_q  <= bus.req_unsigned;
        err_q  <= bad;
      end
      if (accept && !bad) begin
        index_q <= index_d;
        entry_q <= entry_d;
      end
    end
  always_comb begin
    bus.req_ready  = state_q == IDLE;
    bus.resp_valid = state_q == RESP;
    bus.resp_err   = state_q == RESP && err_q;
    bus.resp_rdata = state_q == RESP ? rdata_q : '0;
    bus.ram_wr_en  = wr_en_q;
    bus.ram_index  = index_q;
    bus.ram_entry  = entry_q;
  end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: vector table, corner sequences and random traffic against a byte-array reference
module tb_ram_access_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  int nvec = 0, nerr = 0;
  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];
`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif
  ram_access_ctrl_if bus ();
  ram_access_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always_comb
    for (int k = 0; k < 4; k++) bus.ram_entry_out[k] = mem[bus.ram_index[k][9:0]];
  always @(negedge clk)
    if (bus.ram_wr_en)
      for (int k = 0; k < 4; k++) mem[bus.ram_index[k][9:0]] = bus.ram_entry[k];
  typedef struct {
    logic we; logic [1:0] sz; logic u; logic [31:0] a; logic [31:0] wd; logic e; logic [31:0] rd;
  } vec_t;
  vec_t tbl[18];
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic model(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, output logic e, output logic [31:0] rd);
    int nb;
    longint last;
    nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    last = longint'(a) + nb - 1;
    e = sz == 2'd3 || last >= 1024;
    if (TRAP && ((sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0))) e = 1'b1;
    rd = 0;
    if (!e) begin
      if (we) for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = 8'(wd >> (8 * k));
      else begin
        for (int k = 0; k < nb; k++) rd |= 32'(ref_mem[int'(a) + k]) << (8 * k);
        if (!u && nb < 4 && rd[8*nb-1]) rd |= 32'hFFFF_FFFF << (8 * nb);
      end
    end
  endtask
  task automatic do_req(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, output logic e, output logic [31:0] rd,
                        output int lat, output int wrc, output int wr_at);
    @(negedge clk);
    chk("ready_before_accept", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    bus.req_size = 2'($urandom); bus.req_we = 1'($urandom);
    lat = -1; wrc = 0; wr_at = -1; e = 1'bx; rd = 'x;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.ram_wr_en) begin wrc++; wr_at = k; end
      if (bus.resp_valid) begin lat = k; e = bus.resp_err; rd = bus.resp_rdata; end
    end
    @(posedge clk);
    #1;
    chk("resp_cleared", {bus.resp_valid, bus.resp_err, bus.resp_rdata}, '0);
  endtask
  task automatic run_checked(input string tag, input logic we, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic exp_e, input logic [31:0] exp_rd);
    logic e;
    logic [31:0] rd;
    int lat, wrc, wr_at;
    do_req(we, sz, u, a, wd, e, rd, lat, wrc, wr_at);
    chk({tag, "_err"}, e, exp_e);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_latency"}, lat, exp_e ? 1 : we ? 4 : 3);
    chk({tag, "_wr_count"}, wrc, (!exp_e && we) ? 1 : 0);
    if (wrc == 1) chk({tag, "_wr_cycle"}, wr_at, 2);
  endtask
  initial begin
    logic e;
    logic [31:0] rd;
    int seen, diffs;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = (i >= 'h20 && i < 'h40) ? 8'hAA : 8'($urandom);
      ref_mem[i] = mem[i];
    end
    tbl[0]  = '{1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 0};
    tbl[1]  = '{0, 2, 0, 32'h10, 0, 0, 32'hDEADBEEF};
    tbl[2]  = '{0, 0, 0, 32'h13, 0, 0, 32'hFFFFFFDE};
    tbl[3]  = '{0, 0, 1, 32'h13, 0, 0, 32'h000000DE};
    tbl[4]  = '{1, 1, 0, 32'h20, 32'hFFFF1234, 0, 0};
    tbl[5]  = '{0, 1, 0, 32'h20, 0, 0, 32'h00001234};
    tbl[6]  = '{0, 0, 1, 32'h22, 0, 0, 32'h000000AA};
    tbl[7]  = '{0, 0, 0, 32'h23, 0, 0, 32'hFFFFFFAA};
    tbl[8]  = '{1, 2, 0, 32'd1022, 32'h01020304, 1, 0};
    tbl[9]  = '{1, 3, 0, 32'h40, 32'h55555555, 1, 0};
    tbl[10] = '{1, 0, 0, 32'hFFFFFFFF, 32'h77, 1, 0};
    tbl[11] = '{0, 1, 0, 32'h12, 0, 0, 32'hFFFFDEAD};
    tbl[12] = '{0, 1, 1, 32'h12, 0, 0, 32'h0000DEAD};
    tbl[13] = '{1, 2, 0, 32'h31, 32'h11223344, TRAP, 0};
    tbl[14] = '{0, 2, 1, 32'h31, 0, TRAP, TRAP ? 32'h0 : 32'h11223344};
    tbl[15] = '{0, 2, 0, 32'h30, 0, 0, TRAP ? 32'hAAAAAAAA : 32'h223344AA};
    tbl[16] = '{1, 0, 0, 32'd1023, 32'h5A, 0, 0};
    tbl[17] = '{0, 1, 0, 32'd1023, 0, 1, 0};
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.ram_wr_en}, {1'b1, 35'b0});
    chk("reset_index", bus.ram_index, '0);
    chk("reset_entry", bus.ram_entry, '0);
    reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      model(tbl[i].we, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, e, rd);
      run_checked($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, tbl[i].e, tbl[i].rd);
      if (i == 0) begin
        chk("word_index", bus.ram_index, {32'h13, 32'h12, 32'h11, 32'h10});
        chk("word_entry", bus.ram_entry, 32'hDEADBEEF);
      end
      if (i == 4) begin
        chk("half_index", bus.ram_index, {32'h21, 32'h21, 32'h21, 32'h20});
        chk("half_entry", bus.ram_entry, 32'h12121234);
      end
      if (i == 8) chk("err_keeps_index", bus.ram_index, {4{32'h23}});
    end
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2; bus.req_addr = 32'h50; bus.req_wdata = 32'h99887766;
    @(posedge clk);
    #1 bus.req_valid = 0;
    @(posedge clk);
    #1 chk("strobe_wr_en", bus.ram_wr_en, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_outputs", {bus.req_ready, bus.resp_valid, bus.ram_wr_en}, 3'b100);
    chk("abort_index", bus.ram_index, '0);
    chk("abort_entry", bus.ram_entry, '0);
    @(negedge clk) reset = 1'b0;
    seen = 0;
    repeat (6) @(negedge clk) if (bus.resp_valid) seen++;
    chk("abort_no_resp", seen, 0);
    model(1'b0, 2'd2, 1'b0, 32'h50, 0, e, rd);
    run_checked("after_abort", 1'b0, 2'd2, 1'b0, 32'h50, 0, e, rd);
    for (int i = 0; i < 200; i++) begin
      logic we, u;
      logic [1:0] sz;
      logic [31:0] a, wd;
      int r;
      we = 1'($urandom); u = 1'($urandom); sz = 2'($urandom); wd = $urandom;
      r = $urandom_range(0, 7);
      a = r == 0 ? 32'hFFFFFFFF - $urandom_range(0, 3) : r == 1 ? 32'd1018 + $urandom_range(0, 7) : $urandom_range(0, 63);
      model(we, sz, u, a, wd, e, rd);
      run_checked($sformatf("rand%0d", i), we, sz, u, a, wd, e, rd);
    end
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("memory_image", diffs, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
